// File: rtl/vliw_data_memory.sv
// Multi-port VLIW data memory: self-initialising (mem[i] = i), 1-cycle response,
// byte-enabled writes with highest-port-wins collisions, read-before-write, range errors.
module vliw_data_memory #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  parameter  int NPORTS = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int BW     = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS-1:0]        req_we,
  input  logic [NPORTS*AW-1:0]     req_addr,
  input  logic [NPORTS*DATA_W-1:0] req_wdata,
  input  logic [NPORTS*BW-1:0]     req_be,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        rsp_valid,
  output logic [NPORTS*DATA_W-1:0] rsp_rdata,
  output logic [NPORTS-1:0]        rsp_err,
  output logic                     init_done
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     init_addr_reg, init_addr_next;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NPORTS-1:0] acc, in_range, wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      init_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      init_addr_reg <= init_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_addr_next = init_addr_reg;
    if (state_reg == INIT) begin
      if (init_addr_reg == AW'(DEPTH - 1))
        state_next = RUN;
      else
        init_addr_next = init_addr_reg + AW'(1);
    end
  end

  assign init_done = (state_reg == RUN);
  assign req_ready = {NPORTS{init_done}};

  // Init pattern is the address itself, zero-extended or truncated to the word.
  generate
    if (DATA_W >= AW) begin : g_init_ext
      assign init_word = DATA_W'(init_addr_reg);
    end else begin : g_init_trunc
      assign init_word = init_addr_reg[DATA_W-1:0];
    end
  endgenerate

  // Ports are visited in ascending order so the highest-index port wins each byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == INIT) begin
        mem[init_addr_reg] <= init_word;
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (wr_en[p]) begin
            for (int b = 0; b < BW; b++) begin
              if (req_be[p*BW + b])
                mem[req_addr[p*AW +: AW]][8*b +: 8] <= req_wdata[p*DATA_W + 8*b +: 8];
            end
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [AW-1:0]     addr;
      logic              valid_reg, err_reg;
      logic [DATA_W-1:0] rdata_reg;

      assign addr = req_addr[gi*AW +: AW];

      if (DEPTH == (1 << AW)) begin : g_full
        assign in_range[gi] = 1'b1;
      end else begin : g_partial
        assign in_range[gi] = (addr < AW'(DEPTH));
      end

      assign acc[gi]   = req_valid[gi] & init_done;
      assign wr_en[gi] = acc[gi] & req_we[gi] & in_range[gi];

      // Non-blocking read of mem yields the pre-write word even on a same-cycle write.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          valid_reg <= acc[gi];
          err_reg   <= acc[gi] & ~in_range[gi];
          rdata_reg <= (acc[gi] && !req_we[gi] && in_range[gi]) ? mem[addr] : '0;
        end
      end

      assign rsp_valid[gi]                 = valid_reg;
      assign rsp_err[gi]                   = err_reg;
      assign rsp_rdata[gi*DATA_W +: DATA_W] = rdata_reg;
    end
  endgenerate

endmodule

// File: doc/vliw_data_memory.md
VLIW_DATA_MEMORY -- requirements
Module: vliw_data_memory

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 1024, giving the number of words; any value >= 2 SHALL be legal.
REQ-003 The block SHALL have parameter NPORTS, default 2, giving the number of independent access ports (one per VLIW memory slot).
REQ-004 Derived: AW = $clog2(DEPTH), BW = DATA_W/8; per-port fields SHALL be packed, with port p at slice [p*W +: W].

Interface
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NPORTS  per-port request strobe.
REQ-008 req_we  in  NPORTS  per-port op: 1 = write, 0 = read.
REQ-009 req_addr  in  NPORTS*AW  per-port word address.
REQ-010 req_wdata  in  NPORTS*DATA_W  per-port write data.
REQ-011 req_be  in  NPORTS*BW  per-port byte enables, bit b = bits [8b+7:8b].
REQ-012 req_ready  out  NPORTS  per-port acceptance; all bits SHALL equal init_done.
REQ-013 rsp_valid  out  NPORTS  per-port response strobe.
REQ-014 rsp_rdata  out  NPORTS*DATA_W  per-port read data.
REQ-015 rsp_err  out  NPORTS  per-port address-out-of-range flag.
REQ-016 init_done  out  1  high once initialisation is complete.

Function
REQ-017 The block SHALL have a two-state FSM, INIT -> RUN; it SHALL enter INIT on rst and move to RUN after the last init write; RUN SHALL be held until rst.
REQ-018 In INIT, one word per cycle: mem[i] SHALL be written with i zero-extended or truncated to DATA_W, for i = 0..DEPTH-1 in order.
REQ-019 The first cycle after rst deasserts SHALL write address 0; init_done SHALL rise exactly DEPTH cycles after rst deasserts.
REQ-020 A request SHALL be accepted on port p iff req_valid[p] && req_ready[p]; requests while init_done = 0 SHALL be ignored and produce no response.
REQ-021 Latency SHALL be exactly 1: an accepted request in cycle N SHALL give rsp_valid[p] = 1 for one cycle in N+1; there SHALL be no backpressure on responses.
REQ-022 Read response: rsp_rdata SHALL be the full word as it stood before any write in cycle N.
REQ-023 Write response: rsp_rdata SHALL be 0; the write SHALL update only the bytes whose req_be bit is 1; req_be = 0 SHALL be a legal no-op write that still responds.
REQ-024 Out-of-range address (req_addr >= DEPTH): rsp_err SHALL be 1 and rsp_rdata 0, and memory SHALL be unchanged; otherwise rsp_err SHALL be 0.
REQ-025 Read during a same-cycle write to the same address, from any port: the read SHALL return the old data (read-before-write).
REQ-026 Multiple ports writing the same address in one cycle: each byte SHALL take the value from the highest-index port enabling it; bytes enabled by no port SHALL keep their value.
REQ-027 When rsp_valid[p] = 0, rsp_rdata[p] and rsp_err[p] SHALL be 0.
REQ-028 Port count SHALL be fully generic; no port SHALL stall another.

Reset
REQ-029 While rst = 1: init_done = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and the init address counter SHALL be 0.
REQ-030 rst in any state, including mid-INIT or with responses pending, SHALL cancel pending responses and restart INIT from address 0; all prior contents SHALL be overwritten by the init pattern.
REQ-031 rst SHALL have priority over all requests in the same cycle.

Verification
REQ-032 The bench SHALL cover init and readback: DEPTH = 16, release rst -> init_done rises on cycle 16; a read of address 5 -> rsp_rdata = 0x00000005 one cycle later.
REQ-033 The bench SHALL cover byte-enable writes: port0 writes address 3 with 0xDEADBEEF and be = 4'b0011 -> a later read of address 3 returns 0x0000BEEF.
REQ-034 The bench SHALL cover a write collision: port0 writes 0x11111111 and port1 writes 0x22222222 to address 7 in the same cycle, be = 4'hF -> a read of address 7 returns 0x22222222.
REQ-035 The bench SHALL cover read-before-write: port0 reads address 2 while port1 writes 0xAAAA5555 to address 2 -> port0 returns 0x00000002, and the next read returns 0xAAAA5555.
REQ-036 The bench SHALL cover range errors: DEPTH = 20, a read or write of address 20 -> rsp_err = 1, rsp_rdata = 0, memory unchanged.
REQ-037 The bench SHALL cover reset mid-init: assert rst at init cycle 9, then release -> init_done rises 16 cycles after release, and address 3 reads back 0x00000003.
